axil_switch_led_top: RTL and testbench
======================================

// Module: axil_switch_led_top
// PURPOSE
//   FPGA top-level demonstrator for the AXI4-Lite infrastructure. A switch edge makes an
//   internal AXI4-Lite master write the switch state into a register of an internal
//   AXI4-Lite slave, then read it back; the LED shows bit 0 of the read-back data.
//   The bus is fully internal: only the clock, reset, switch and LED reach the pins.
// PARAMETERS
//   ADDR_WIDTH   4   AXI4-Lite address width (byte addresses, 4 x 32-bit registers)
//   DATA_WIDTH   32  AXI4-Lite data width
//   SYNC_STAGES  2   flip-flop stages synchronising sw into sysclk domain (>=2)
//   LED_REG_ADDR 0   byte address of the register written/read (must be 4-aligned)
// PORTS
//   sysclk  input   1  system clock, 125 MHz; all logic on rising edge
//   rst_n   input   1  asynchronous, active-low reset
//   sw      input   1  sw[0]: asynchronous slide switch
//   led     output  1  led[0]: bit 0 of last AXI read-back data
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync release): led=0, all slave regs=0, sync chain=0,
//     last_written=0, master IDLE, every VALID/READY low.
//   - sw[0] passes SYNC_STAGES flops -> sw_s. No other debounce.
//   - Master FSM: IDLE -> WR_ADDR_DATA -> WR_RESP -> RD_ADDR -> RD_DATA -> IDLE.
//     IDLE: if sw_s != last_written, latch wdata={31'b0,sw_s}, last_written<=sw_s, go WR.
//     WR_ADDR_DATA: awvalid and wvalid raised together, addr=LED_REG_ADDR, wstrb=4'hF;
//       each VALID drops independently after its own handshake; advance when both done.
//     WR_RESP: bready=1; on bvalid go RD_ADDR.
//     RD_ADDR: arvalid=1, araddr=LED_REG_ADDR; on arready go RD_DATA.
//     RD_DATA: rready=1; on rvalid, led<=rdata[0], go IDLE.
//   - VALID signals never depend combinationally on READY; once raised, held with stable
//     payload until handshake.
//   - Slave: 4 R/W regs at 0x0,0x4,0x8,0xC; accepts AW and W in either order or same
//     cycle; byte writes honour wstrb; bvalid the cycle after both accepted, held until
//     bready; arready 1 cycle after arvalid, rvalid the next cycle, held until rready.
//     bresp=rresp=2'b00 (OKAY) always; address bits [1:0] ignored.
//   - Latency: led reflects a new sw level at most 16 sysclk cycles after the sw pin
//     change (2 sync + ~10 bus cycles); led never glitches, changes only in RD_DATA.
//   - sw toggling mid-transaction: current transaction completes unchanged; IDLE then
//     compares sw_s to last_written and starts another if they differ (final led level
//     always equals final stable sw). Pulses shorter than the transaction are missed.
//   - Reset mid-transaction: everything returns to reset values immediately; on
//     release, if sw=1 a new write/read cycle starts and led goes to 1.
// TESTING
//   1. rst_n=0 then 1, sw=0 for 100 ns -> led=0, no bus activity (awvalid/arvalid=0).
//   2. sw 0->1 at t=100 ns -> one write of 32'h1 to 0x0, one read returning 32'h1;
//      led=1 within 16 cycles (128 ns), held for the following 1000 ns.
//   3. sw 1->0 -> write 32'h0, read 32'h0, led=0 within 16 cycles; stays 0 for 200 ns.
//   4. sw toggles 0->1->0 inside one transaction -> final led=0, at most 2 write/read
//      pairs, bresp/rresp always 2'b00.
//   5. rst_n pulsed low while sw=1 and led=1 -> led=0 immediately; after release led=1
//      within 16 cycles.
//   6. Protocol checker on internal bus: no VALID drop before handshake, payload stable
//      while VALID && !READY, exactly one B per write and one R per AR.

Source files
------------

// File: rtl/axil_switch_led.sv
// Switch-to-LED demonstrator: a small AXI4-Lite master writes the synchronised switch
// level into a 4-register AXI4-Lite slave, reads it back, and drives the LED from bit 0.
module axil_switch_led_top #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int LED_REG_ADDR = 0
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sw,
  output logic led
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] REG_ADDR = ADDR_WIDTH'(LED_REG_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_s;
  logic                   last_written;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic                   aw_done, w_done;

  logic                   awvalid, awready, wvalid, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid, rready;
  logic [ADDR_WIDTH-1:0]  awaddr, araddr;
  logic [DATA_WIDTH-1:0]  wdata, rdata;
  logic [STRB_WIDTH-1:0]  wstrb;
  logic [1:0]             bresp, rresp;
  logic                   aw_hs, w_hs;

  logic [DATA_WIDTH-1:0]  regs [4];
  logic [1:0]             aw_idx_q;
  logic [DATA_WIDTH-1:0]  w_data_q;
  logic [STRB_WIDTH-1:0]  w_strb_q;
  logic                   aw_got, w_got;
  logic [1:0]             wr_idx;
  logic [DATA_WIDTH-1:0]  wr_data_eff;
  logic [STRB_WIDTH-1:0]  wr_strb_eff;
  logic                   unused_bits;

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  // Master VALID/READY decode purely from registered state, never from the slave's READY.
  assign awvalid = (state_q == WR_ADDR_DATA) && !aw_done;
  assign wvalid  = (state_q == WR_ADDR_DATA) && !w_done;
  assign bready  = (state_q == WR_RESP);
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);
  assign awaddr  = REG_ADDR;
  assign araddr  = REG_ADDR;
  assign wdata   = wr_data_q;
  assign wstrb   = '1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (sw_s != last_written) state_d = WR_ADDR_DATA;
      WR_ADDR_DATA: if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_RESP;
      WR_RESP:      if (bvalid) state_d = RD_ADDR;
      RD_ADDR:      if (arready) state_d = RD_DATA;
      RD_DATA:      if (rvalid) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_written <= 1'b0;
      wr_data_q    <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      led          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == WR_ADDR_DATA) begin
        wr_data_q    <= {{(DATA_WIDTH-1){1'b0}}, sw_s};
        last_written <= sw_s;
      end
      if (state_q == WR_ADDR_DATA && state_d == WR_RESP) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state_q == RD_DATA && rvalid) led <= rdata[0];
    end
  end

  // Slave: AW and W may arrive in either order; the write commits once both are held.
  assign awready     = awvalid && !aw_got && !bvalid;
  assign wready      = wvalid && !w_got && !bvalid;
  assign wr_idx      = aw_hs ? awaddr[3:2] : aw_idx_q;
  assign wr_data_eff = w_hs ? wdata : w_data_q;
  assign wr_strb_eff = w_hs ? wstrb : w_strb_q;
  assign bresp       = 2'b00;
  assign rresp       = 2'b00;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid   <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_idx_q <= awaddr[3:2];
        aw_got   <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_got    <= 1'b1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wr_strb_eff[b]) regs[wr_idx][8*b +: 8] <= wr_data_eff[8*b +: 8];
        end
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bvalid <= 1'b1;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read path: ARREADY one cycle after ARVALID, RVALID the cycle after the AR handshake.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= arvalid && !arready && !rvalid;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= regs[araddr[3:2]];
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign unused_bits = ^{awaddr[1:0], araddr[1:0], rdata[DATA_WIDTH-1:1], bresp, rresp};

endmodule

// File: tb/tb_axil_switch_led_top.sv
// Directed bench for axil_switch_led_top: scoreboarded write/read data on the internal bus,
// protocol stability checks, LED latency and reset behaviour.
module tb_axil_switch_led_top;

  logic sysclk;
  logic rst_n;
  logic sw;
  logic led;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wq[$];
  logic [31:0] exp_rq[$];

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int valid_seen = 0;

  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic        p_arvalid, p_arready, p_rvalid, p_rready, p_led, p_r_hs;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata, p_rdata;

  axil_switch_led_top dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .sw     (sw),
    .led    (led)
  );

  initial begin
    sysclk = 1'b0;
    forever #4 sysclk = ~sysclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the switch and, when a transaction is due, queue the value it must carry.
  task automatic applyStimulus(input logic value, input bit expect_txn);
    sw = value;
    if (expect_txn) begin
      exp_wq.push_back({31'b0, value});
      exp_rq.push_back({31'b0, value});
    end
    $display("[TB] sw <= %0b at %0t", value, $time);
  endtask

  task automatic waitLed(input logic value, input string tag);
    int n;
    n = 0;
    while (led !== value && n < 16) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput(tag, {31'b0, led}, {31'b0, value});
  endtask

  task automatic drainScoreboard(input string tag);
    int n;
    n = 0;
    while ((exp_rq.size() != 0 || dut.rready) && n < 64) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput(tag, exp_rq.size(), 0);
  endtask

  task automatic holdLed(input logic value, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sysclk);
      if (led !== value) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_w_per_aw"}, w_cnt, aw_cnt);
    checkOutput({tag, "_b_per_aw"}, b_cnt, aw_cnt);
    checkOutput({tag, "_r_per_ar"}, r_cnt, ar_cnt);
  endtask

  // Bus monitor: sampled mid-cycle, so VALID && READY here is the handshake at the next edge.
  always @(negedge sysclk) begin
    if (!rst_n) begin
      p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_bvalid = 0; p_bready = 0;
      p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0; p_r_hs = 0;
      p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_rdata = 0;
      p_led = led;
    end else begin
      if (p_awvalid && !p_awready)
        checkOutput("aw_hold", {27'b0, dut.awvalid, dut.awaddr}, {27'b0, 1'b1, p_awaddr});
      if (p_wvalid && !p_wready) begin
        checkOutput("w_hold_valid", {31'b0, dut.wvalid}, 32'd1);
        checkOutput("w_hold_data", dut.wdata, p_wdata);
      end
      if (p_bvalid && !p_bready) checkOutput("b_hold", {31'b0, dut.bvalid}, 32'd1);
      if (p_arvalid && !p_arready)
        checkOutput("ar_hold", {27'b0, dut.arvalid, dut.araddr}, {27'b0, 1'b1, p_araddr});
      if (p_rvalid && !p_rready) begin
        checkOutput("r_hold_valid", {31'b0, dut.rvalid}, 32'd1);
        checkOutput("r_hold_data", dut.rdata, p_rdata);
      end
      if (led !== p_led) checkOutput("led_only_on_read", {31'b0, p_r_hs}, 32'd1);

      if (dut.awvalid || dut.arvalid) valid_seen++;
      if (dut.awvalid && dut.awready) begin
        aw_cnt++;
        checkOutput("awaddr", {28'b0, dut.awaddr}, 32'h0);
      end
      if (dut.wvalid && dut.wready) begin
        w_cnt++;
        checkOutput("wstrb", {28'b0, dut.wstrb}, 32'hF);
        if (exp_wq.size() == 0) checkOutput("w_unexpected", 32'd1, 32'd0);
        else checkOutput("wdata", dut.wdata, exp_wq.pop_front());
      end
      if (dut.bvalid && dut.bready) begin
        b_cnt++;
        checkOutput("bresp", {30'b0, dut.bresp}, 32'h0);
      end
      if (dut.arvalid && dut.arready) begin
        ar_cnt++;
        checkOutput("araddr", {28'b0, dut.araddr}, 32'h0);
      end
      if (dut.rvalid && dut.rready) begin
        r_cnt++;
        checkOutput("rresp", {30'b0, dut.rresp}, 32'h0);
        if (exp_rq.size() == 0) checkOutput("r_unexpected", 32'd1, 32'd0);
        else checkOutput("rdata", dut.rdata, exp_rq.pop_front());
      end

      p_awvalid = dut.awvalid; p_awready = dut.awready; p_awaddr = dut.awaddr;
      p_wvalid  = dut.wvalid;  p_wready  = dut.wready;  p_wdata  = dut.wdata;
      p_bvalid  = dut.bvalid;  p_bready  = dut.bready;
      p_arvalid = dut.arvalid; p_arready = dut.arready; p_araddr = dut.araddr;
      p_rvalid  = dut.rvalid;  p_rready  = dut.rready;  p_rdata  = dut.rdata;
      p_r_hs    = dut.rvalid && dut.rready;
      p_led     = led;
    end
  end

  initial begin
    int start_aw;
    int n;

    // Reset and idle with the switch low.
    sw    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_led", {31'b0, led}, 32'd0);
    checkOutput("reset_valids", {30'b0, dut.awvalid, dut.arvalid}, 32'd0);
    #1 rst_n = 1'b1;
    #100;
    @(negedge sysclk);
    checkOutput("idle_led", {31'b0, led}, 32'd0);
    checkOutput("idle_no_bus_activity", valid_seen, 0);

    // Switch on: one write/read of 1, LED follows and holds.
    #1 applyStimulus(1'b1, 1'b1);
    waitLed(1'b1, "sw_on_led_latency");
    drainScoreboard("sw_on_drain");
    holdLed(1'b1, 125, "sw_on_hold");
    checkCounts("sw_on");
    checkOutput("sw_on_one_write", aw_cnt, 1);

    // Switch off.
    #1 applyStimulus(1'b0, 1'b1);
    waitLed(1'b0, "sw_off_led_latency");
    drainScoreboard("sw_off_drain");
    holdLed(1'b0, 25, "sw_off_hold");
    checkCounts("sw_off");

    // Toggle back to 0 while the write of 1 is in flight.
    start_aw = aw_cnt;
    #1 applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!dut.awvalid && n < 10) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput("toggle_txn_started", {31'b0, dut.awvalid}, 32'd1);
    #1 applyStimulus(1'b0, 1'b1);
    drainScoreboard("toggle_drain");
    repeat (4) @(negedge sysclk);
    checkOutput("toggle_final_led", {31'b0, led}, 32'd0);
    checkOutput("toggle_two_pairs", aw_cnt - start_aw, 2);
    checkCounts("toggle");

    // Reset pulse while the LED is lit.
    #1 applyStimulus(1'b1, 1'b1);
    waitLed(1'b1, "pre_reset_led");
    drainScoreboard("pre_reset_drain");
    @(negedge sysclk);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset_led", {31'b0, led}, 32'd0);
    repeat (2) @(negedge sysclk);
    checkOutput("reset_hold_valids", {30'b0, dut.awvalid, dut.arvalid}, 32'd0);
    #1 applyStimulus(1'b1, 1'b1);
    rst_n = 1'b1;
    waitLed(1'b1, "post_reset_led");
    drainScoreboard("post_reset_drain");
    checkCounts("post_reset");

    repeat (4) @(negedge sysclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
